// File: rtl/vga_vram_sched.sv
// vga_vram_sched: single-port VRAM scheduler between the VGA scan-out and one pixel writer.
// Display reads own the RAM port while valid=1. Writer requests are queued in a small FIFO
// and drained into VRAM only during blanking, one write per cycle, in FIFO order.
// Optional feature macro: VRAM_DROP_CNT_EN (writer never stalls, overflow and
// out-of-range writes are discarded and counted in drop_cnt).
module vga_vram_sched #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 1
) (
    input  logic                              pclk,
    input  logic                              reset,
    input  logic                              valid,
    input  logic [9:0]                        h_addr,
    input  logic [9:0]                        v_addr,
    input  logic                              wr_req,
    input  logic [ADDR_W-1:0]                 wr_addr,
    input  logic [DATA_W-1:0]                 wr_data,
    output logic                              wr_ready,
    output logic [ADDR_W-1:0]                 ram_addr,
    output logic                              ram_we,
    output logic [DATA_W-1:0]                 ram_wdata,
    input  logic [DATA_W-1:0]                 ram_rdata,
    output logic [DATA_W-1:0]                 pix_data,
    output logic                              pix_valid,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic [7:0]                        drop_cnt
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH+1);
    localparam logic [ADDR_W-1:0] NUM_PIX = ADDR_W'(307200);

    typedef enum logic [1:0] {
        IDLE,
        DISP,
        DRAIN
    } state_t;

    logic [ADDR_W-1:0] mem_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;

    state_t            state;
    logic              full, in_range, push, pop;
    logic [ADDR_W-1:0] disp_addr;

    assign full       = (count == CNT_W'(FIFO_DEPTH));
    assign in_range   = (wr_addr < NUM_PIX);
    assign fifo_count = count;

`ifdef VRAM_DROP_CNT_EN
    logic drop;
    assign wr_ready = 1'b1;
    // Anything acknowledged that cannot be stored is counted instead.
    assign drop     = wr_req & (full | ~in_range);
`else
    // Space is judged from the registered count, so a same-cycle pop never frees a slot.
    assign wr_ready = ~full;
    assign drop_cnt = 8'd0;
`endif

    // Out-of-range writes complete the handshake but are never stored.
    assign push = wr_req & wr_ready & ~full & in_range;

    // 640*v + h as shift-and-add; fits in 19 bits for the full 640x480 frame.
    assign disp_addr = (ADDR_W'(v_addr) << 9) + (ADDR_W'(v_addr) << 7) + ADDR_W'(h_addr);

    // Same-cycle arbitration: display owns the port whenever valid is high.
    always_comb begin
        state     = IDLE;
        pop       = 1'b0;
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (valid) begin
            state    = DISP;
            ram_addr = disp_addr;
        end else if (count != '0) begin
            state     = DRAIN;
            pop       = 1'b1;
            ram_addr  = mem_addr[rd_ptr];
            ram_wdata = mem_data[rd_ptr];
            ram_we    = 1'b1;
        end
    end

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge pclk) begin
        if (push) begin
            mem_addr[wr_ptr] <= wr_addr;
            mem_data[wr_ptr] <= wr_data;
        end
    end

    // FIFO pointers and occupancy; reset discards anything pending, even mid-drain.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Read pipeline: one-cycle delay on valid and the returned pixel.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            pix_valid <= 1'b0;
            pix_data  <= '0;
        end else begin
            pix_valid <= valid;
            pix_data  <= valid ? ram_rdata : '0;
        end
    end

`ifdef VRAM_DROP_CNT_EN
    // Saturating count of discarded writes.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset)
            drop_cnt <= 8'd0;
        else if (drop && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
    end
`endif

    logic unused_state;
    assign unused_state = (state == DRAIN) ^ (state == IDLE);

endmodule

// File: tb/tb_vga_vram_sched.sv
// Directed self-checking bench for vga_vram_sched (default parameters).
module tb_vga_vram_sched;

    logic        pclk = 1'b0;
    logic        reset;
    logic        valid;
    logic [9:0]  h_addr, v_addr;
    logic        wr_req;
    logic [18:0] wr_addr;
    logic [0:0]  wr_data;
    logic        wr_ready;
    logic [18:0] ram_addr;
    logic        ram_we;
    logic [0:0]  ram_wdata;
    logic [0:0]  ram_rdata;
    logic [0:0]  pix_data;
    logic        pix_valid;
    logic [2:0]  fifo_count;
    logic [7:0]  drop_cnt;

    int nchk = 0;
    int nerr = 0;
    int exp_drop = 0;

    vga_vram_sched dut (
        .pclk(pclk), .reset(reset), .valid(valid), .h_addr(h_addr), .v_addr(v_addr),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .pix_data(pix_data), .pix_valid(pix_valid), .fifo_count(fifo_count), .drop_cnt(drop_cnt)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called just after a negedge; holds the request until accepted (bounded).
    task automatic push(input logic [18:0] a, input logic d);
        bit ok = 0;
        wr_req = 1'b1; wr_addr = a; wr_data = d;
        for (int n = 0; n < 20 && !ok; n++) begin
            #1;
            if (wr_ready) ok = 1;
            @(negedge pclk);
        end
        wr_req = 1'b0;
        chk("push_accept", 32'(ok), 32'd1);
    endtask

    // Step to the next negedge and check one drain write.
    task automatic drain_step(input string tag, input logic [18:0] a, input logic d, input int cnt);
        chk({tag, "_we"}, 32'(ram_we), 32'd1);
        chk({tag, "_addr"}, 32'(ram_addr), 32'(a));
        chk({tag, "_wdata"}, 32'(ram_wdata), 32'(d));
        chk({tag, "_cnt"}, 32'(fifo_count), 32'(cnt));
        @(negedge pclk); #1;
    endtask

    initial begin
        reset = 1'b1; valid = 0; h_addr = 0; v_addr = 0;
        wr_req = 0; wr_addr = 0; wr_data = 0; ram_rdata = 0;

        // 1: reset state
        repeat (3) @(posedge pclk);
        @(negedge pclk); reset = 1'b0; #1;
        chk("rst_we", 32'(ram_we), 0);
        chk("rst_ready", 32'(wr_ready), 1);
        chk("rst_cnt", 32'(fifo_count), 0);
        chk("rst_pvld", 32'(pix_valid), 0);
        chk("rst_pdata", 32'(pix_data), 0);
        chk("rst_drop", 32'(drop_cnt), 0);

        // 2: display address and read pipeline
        @(negedge pclk); valid = 1; h_addr = 5; v_addr = 2; ram_rdata = 1; #1;
        chk("disp_addr", 32'(ram_addr), 1285);
        chk("disp_we", 32'(ram_we), 0);
        @(negedge pclk); h_addr = 639; v_addr = 479; ram_rdata = 0; #1;
        chk("pix_valid", 32'(pix_valid), 1);
        chk("pix_data1", 32'(pix_data), 1);
        chk("disp_addr_max", 32'(ram_addr), 307199);
        @(negedge pclk); #1;
        chk("pix_data0", 32'(pix_data), 0);

        // 3: writes queued during display, drained in blanking
        push(100, 1); chk("q_we0", 32'(ram_we), 0);
        push(200, 0); chk("q_we1", 32'(ram_we), 0);
        push(300, 1); chk("q_we2", 32'(ram_we), 0);
        #1 chk("q_cnt3", 32'(fifo_count), 3);
        valid = 0; #1;
        drain_step("d100", 100, 1, 3);
        drain_step("d200", 200, 0, 2);
        drain_step("d300", 300, 1, 1);
        chk("d_end_we", 32'(ram_we), 0);
        chk("d_end_addr", 32'(ram_addr), 0);
        chk("d_end_cnt", 32'(fifo_count), 0);
        chk("pix_valid_off", 32'(pix_valid), 0);

        // out-of-range write: acknowledged, never stored or written
        @(negedge pclk); wr_req = 1; wr_addr = 307200; wr_data = 1; #1;
        chk("oor_ready", 32'(wr_ready), 1);
`ifdef VRAM_DROP_CNT_EN
        exp_drop++;
`endif
        @(negedge pclk); wr_req = 0; #1;
        chk("oor_cnt", 32'(fifo_count), 0);
        chk("oor_we", 32'(ram_we), 0);
        chk("oor_drop", 32'(drop_cnt), 32'(exp_drop));

        // 4: overflow during display
        @(negedge pclk); valid = 1; h_addr = 0; v_addr = 0;
        push(10, 1); push(20, 0); push(30, 1); push(40, 1);
        #1 chk("full_cnt", 32'(fifo_count), 4);
`ifdef VRAM_DROP_CNT_EN
        chk("full_ready", 32'(wr_ready), 1);
        wr_req = 1; wr_addr = 50; wr_data = 1;
        @(negedge pclk); wr_addr = 307200;
        @(negedge pclk); wr_req = 0; #1;
        exp_drop += 2;
        chk("ovf_drop", 32'(drop_cnt), 32'(exp_drop));
        chk("ovf_cnt", 32'(fifo_count), 4);
        valid = 0; #1;
        drain_step("o10", 10, 1, 4);
        drain_step("o20", 20, 0, 3);
        drain_step("o30", 30, 1, 2);
        drain_step("o40", 40, 1, 1);
`else
        chk("full_ready", 32'(wr_ready), 0);
        wr_req = 1; wr_addr = 50; wr_data = 1;
        @(negedge pclk); #1;
        chk("hold_cnt", 32'(fifo_count), 4);
        chk("hold_we", 32'(ram_we), 0);
        valid = 0; #1;
        chk("pop_noready", 32'(wr_ready), 0);
        drain_step("o10", 10, 1, 4);
        chk("freed_ready", 32'(wr_ready), 1);
        drain_step("o20", 20, 0, 3);
        wr_req = 0; #1;
        drain_step("o30", 30, 1, 3);
        drain_step("o40", 40, 1, 2);
        drain_step("o50", 50, 1, 1);
        chk("no_drop", 32'(drop_cnt), 0);
`endif
        chk("o_end_we", 32'(ram_we), 0);
        chk("o_end_cnt", 32'(fifo_count), 0);

        // 5: valid rises mid-drain, display wins
        @(negedge pclk); valid = 1;
        push(7, 1); push(8, 0); push(9, 1);
        valid = 0; #1;
        drain_step("p7", 7, 1, 3);
        valid = 1; h_addr = 1; v_addr = 1; #1;
        chk("pre_we", 32'(ram_we), 0);
        chk("pre_addr", 32'(ram_addr), 641);
        chk("pre_cnt", 32'(fifo_count), 2);
        @(negedge pclk); #1;
        chk("pre_cnt_hold", 32'(fifo_count), 2);
        chk("pre_we_hold", 32'(ram_we), 0);
        valid = 0; #1;
        drain_step("p8", 8, 0, 2);
        drain_step("p9", 9, 1, 1);
        chk("p_end_we", 32'(ram_we), 0);

        // 6: reset mid-drain discards pending writes
        @(negedge pclk); valid = 1;
        push(11, 1); push(12, 0); push(13, 1);
        valid = 0; #1;
        chk("r_we_pre", 32'(ram_we), 1);
        chk("r_cnt_pre", 32'(fifo_count), 3);
        reset = 1; #1;
        chk("r_we", 32'(ram_we), 0);
        chk("r_cnt", 32'(fifo_count), 0);
        @(negedge pclk); @(negedge pclk); reset = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("r_post_we", 32'(ram_we), 0);
            chk("r_post_cnt", 32'(fifo_count), 0);
            @(negedge pclk);
        end
        chk("r_drop", 32'(drop_cnt), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
